// File: rtl/wb_host_master.sv
// Single-outstanding pipelined Wishbone master: one bus cycle per host request, done_o 2+ cycles after accept.
// Optional bus timeout via WB_HOST_MASTER_TIMEOUT_EN; req_i is ignored while busy (no queueing).
module wb_host_master #(
  parameter int ADDR_WIDTH  = 4,
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           dat_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            resp_o,
  output logic [31:0]           dat_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:2] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_BACKOFF} state_t;

  localparam logic [1:0] RESP_ACK = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b01;
  localparam logic [1:0] RESP_TMO = 2'b10;
  localparam logic [1:0] RESP_RTY = 2'b11;
  localparam logic [3:0] MAX_RTY  = 4'(MAX_RETRIES);

  state_t                state_q, state_d;
  logic [3:0]            rty_q, rty_d;
  logic                  busy_d, done_d, cyc_d, stb_d, we_d;
  logic [1:0]            resp_d;
  logic [31:0]           rdat_d, wdat_d;
  logic [ADDR_WIDTH-1:2] adr_d;
  logic [3:0]            sel_d;
  logic                  tmo_hit;

  // Byte-lane bits of the address never reach the bus.
  logic [1:0] adr_lsb_unused;
  assign adr_lsb_unused = adr_i[1:0];

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  logic [15:0] tmo_q, tmo_d;

  // Zero outside REQ/WAIT, so every entry to REQ (first issue or retry) restarts the count.
  always_comb begin
    tmo_d = 16'd0;
    if (state_q == S_REQ || state_q == S_WAIT) tmo_d = tmo_q + 16'd1;
  end

  assign tmo_hit = (tmo_q + 16'd1) == TMO_LIMIT;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tmo_q <= 16'd0;
    else          tmo_q <= tmo_d;
  end
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rty_d   = rty_q;
    done_d  = 1'b0;
    resp_d  = resp_o;
    rdat_d  = dat_o;
    we_d    = wb_we_o;
    adr_d   = wb_adr_o;
    sel_d   = wb_sel_o;
    wdat_d  = wb_dat_o;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_REQ;
          we_d    = we_i;
          adr_d   = adr_i[ADDR_WIDTH-1:2];
          sel_d   = sel_i;
          wdat_d  = dat_i;
          rty_d   = 4'd0;
        end
      end
      S_REQ, S_WAIT: begin
        // err > rty > ack; a real response beats a timeout landing in the same cycle.
        if (wb_err_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          resp_d  = RESP_ERR;
        end else if (wb_rty_i) begin
          if (rty_q < MAX_RTY) begin
            rty_d   = rty_q + 4'd1;
            state_d = S_BACKOFF;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            resp_d  = RESP_RTY;
          end
        end else if (wb_ack_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          resp_d  = RESP_ACK;
          if (!wb_we_o) rdat_d = wb_dat_i;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          resp_d  = RESP_TMO;
        end else if (state_q == S_REQ && !wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_BACKOFF: state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase
    // Bus controls are registered from the next state so they track it with no extra cycle.
    cyc_d  = (state_d == S_REQ) || (state_d == S_WAIT);
    stb_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      rty_q    <= 4'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      resp_o   <= 2'b00;
      dat_o    <= 32'd0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= 4'd0;
      wb_dat_o <= 32'd0;
    end else begin
      state_q  <= state_d;
      rty_q    <= rty_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      resp_o   <= resp_d;
      dat_o    <= rdat_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= we_d;
      wb_adr_o <= adr_d;
      wb_sel_o <= sel_d;
      wb_dat_o <= wdat_d;
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master: a scripted pipelined slave answers each strobe phase,
// expected completions are queued at issue time and compared when done_o pulses.
module tb_wb_host_master;

  localparam int AW = 4;
  localparam int MR = 3;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic          req  = 1'b0;
  logic          we   = 1'b0;
  logic [AW-1:0] adr  = '0;
  logic [3:0]    sel  = '0;
  logic [31:0]   wdat = '0;
  logic          busy, done;
  logic [1:0]    resp;
  logic [31:0]   rdat;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:2] wb_adr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_wdat;
  logic          wb_ack   = 1'b0;
  logic          wb_err   = 1'b0;
  logic          wb_rty   = 1'b0;
  logic          wb_stall = 1'b0;
  logic [31:0]   slv_rdata = '0;

  wb_host_master #(.ADDR_WIDTH(AW), .MAX_RETRIES(MR), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_i(req), .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(wdat),
    .busy_o(busy), .done_o(done), .resp_o(resp), .dat_o(rdat),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_wdat),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall),
    .wb_dat_i(slv_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [31:0] model_dat = '0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] dat;
  } exp_t;
  exp_t exp_q[$];

  // Slave script: stall count per phase, response in the stall-drop cycle or one cycle later,
  // and one response code per phase (0 ack, 1 err, 2 rty, 3 err+ack; empty queue = silent).
  int slv_stall = 0;
  bit slv_same  = 1'b0;
  int slv_resp[$];
  bit pending   = 1'b0;
  int stb_vis   = 0;

  function automatic void drive_resp();
    int code;
    if (slv_resp.size() == 0) return;
    code = slv_resp.pop_front();
    case (code)
      0: wb_ack = 1'b1;
      1: wb_err = 1'b1;
      2: wb_rty = 1'b1;
      3: begin wb_err = 1'b1; wb_ack = 1'b1; end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      stb_vis = 0;
    end else if (wb_stb) begin
      stb_vis++;
      if (stb_vis <= slv_stall) wb_stall = 1'b1;
      else if (slv_same)        drive_resp();
      else                      pending = 1'b1;
    end else begin
      stb_vis = 0;
      if (pending && wb_cyc) drive_resp();
      pending = 1'b0;
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got resp=%b dat=%h", resp, rdat);
      end else begin
        e = exp_q.pop_front();
        if (resp !== e.resp || rdat !== e.dat) begin
          errors++;
          $display("FAIL sb_result got resp=%b dat=%h expected resp=%b dat=%h",
                   resp, rdat, e.resp, e.dat);
        end
      end
    end
  end

  task automatic issue_req(input logic w, input logic [AW-1:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    req = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Measures one transaction from the current negedge; stops at the done_o cycle.
  task automatic run_phase(input int budget, output int stb_n, output int rises,
                           output int gaps, output int done_at,
                           output logic [1:0] a_first, output logic [31:0] d_first,
                           output logic [4:0] ws_first);
    logic prev = 1'b0;
    stb_n = 0; rises = 0; gaps = 0; done_at = -1;
    a_first = 'x; d_first = 'x; ws_first = 'x;
    for (int i = 0; i < budget; i++) begin
      if (wb_stb) begin
        if (stb_n == 0) begin a_first = wb_adr; d_first = wb_wdat; ws_first = {wb_we, wb_sel}; end
        stb_n++;
        if (!prev) rises++;
      end
      prev = wb_stb;
      if (busy && !wb_cyc) gaps++;
      if (done) begin done_at = i; break; end
      @(negedge clk);
    end
  endtask

  int sn, rs, gp, dt;
  logic [1:0] af;
  logic [31:0] df;
  logic [4:0] wsf;

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_wdat} !== '0) begin
      errors++;
      $display("FAIL reset_bus got %b/%b/%b adr=%b sel=%h dat=%h required all 0",
               wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_wdat);
    end
    checks++;
    if ({busy, done, resp, rdat} !== '0) begin
      errors++;
      $display("FAIL reset_host got busy=%b done=%b resp=%b dat=%h required all 0",
               busy, done, resp, rdat);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    repeat (2) @(negedge clk);
    slv_stall = 0; slv_same = 1'b0; slv_resp = {0}; slv_rdata = 32'hAAAA5555;
    exp_q.push_back(exp_t'{resp: 2'b00, dat: model_dat});
    issue_req(1'b1, 4'h4, 4'hF, 32'hDEADBEEF);
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (af !== 2'b01) begin errors++; $display("FAIL write_adr got %b required 01", af); end
    checks++;
    if (df !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dat got %h required deadbeef", df); end
    checks++;
    if (wsf !== 5'b1_1111) begin errors++; $display("FAIL write_we_sel got %b required 11111", wsf); end
    checks++;
    if (dt !== 2) begin errors++; $display("FAIL write_latency got %0d required 2", dt); end
  endtask

  task automatic test_read_stall();
    int pre = 0;
    repeat (2) @(negedge clk);
    slv_stall = 3; slv_same = 1'b1; slv_resp = {0}; slv_rdata = 32'h12345678;
    exp_q.push_back(exp_t'{resp: 2'b00, dat: 32'h12345678});
    model_dat = 32'h12345678;
    issue_req(1'b0, 4'h8, 4'hF, 32'h0);
    if (wb_stb) pre++;
    @(negedge clk);
    if (wb_stb) pre++;
    // A request while busy must be dropped, not captured.
    req = 1'b1; adr = 4'hC; we = 1'b1;
    @(negedge clk);
    req = 1'b0;
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (af !== 2'b10) begin errors++; $display("FAIL stray_req_adr got %b required 10", af); end
    checks++;
    if (pre + sn !== 4) begin errors++; $display("FAIL stall_stb_cycles got %0d required 4", pre + sn); end
    checks++;
    if (2 + dt !== 4) begin errors++; $display("FAIL stall_latency got %0d required 4", 2 + dt); end
    slv_stall = 0;
  endtask

  task automatic test_retry();
    repeat (2) @(negedge clk);
    slv_same = 1'b0; slv_resp = {2, 2, 2, 2};
    exp_q.push_back(exp_t'{resp: 2'b11, dat: model_dat});
    issue_req(1'b1, 4'h0, 4'h1, 32'h5A5A5A5A);
    run_phase(60, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (rs !== MR + 1) begin errors++; $display("FAIL retry_phases got %0d required %0d", rs, MR + 1); end
    checks++;
    if (gp !== MR) begin errors++; $display("FAIL retry_backoff got %0d required %0d", gp, MR); end
    checks++;
    if (sn !== MR + 1) begin errors++; $display("FAIL retry_stb_cycles got %0d required %0d", sn, MR + 1); end
  endtask

  task automatic test_error();
    repeat (2) @(negedge clk);
    slv_same = 1'b0; slv_resp = {3}; slv_rdata = 32'hBAD0BAD0;
    exp_q.push_back(exp_t'{resp: 2'b01, dat: model_dat});
    issue_req(1'b0, 4'h4, 4'hF, 32'h0);
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (dt !== 2) begin errors++; $display("FAIL error_latency got %0d required 2", dt); end
  endtask

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    repeat (2) @(negedge clk);
    slv_same = 1'b0; slv_resp.delete();
    exp_q.push_back(exp_t'{resp: 2'b10, dat: model_dat});
    issue_req(1'b0, 4'h8, 4'hF, 32'h0);
    run_phase(40, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (dt !== TO) begin errors++; $display("FAIL timeout_latency got %0d required %0d", dt, TO); end
    repeat (3) @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release got cyc=%b busy=%b required 0/0", wb_cyc, busy);
    end
  endtask
`else
  task automatic test_timeout();
    int dc;
    repeat (2) @(negedge clk);
    slv_same = 1'b0; slv_resp.delete();
    dc = done_cnt;
    issue_req(1'b0, 4'h8, 4'hF, 32'h0);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== dc || wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_hold got dones=%0d cyc=%b required 0/1", done_cnt - dc, wb_cyc);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_dat = '0;
  endtask
`endif

  task automatic test_async_reset();
    int dc;
    repeat (2) @(negedge clk);
    slv_same = 1'b0; slv_resp.delete();
    issue_req(1'b0, 4'h4, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop got cyc=%b stb=%b busy=%b required 0", wb_cyc, wb_stb, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_dat = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== dc || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_done got dones=%0d required 0", done_cnt - dc);
    end
    slv_resp = {0}; slv_rdata = 32'h0F0F1234;
    exp_q.push_back(exp_t'{resp: 2'b00, dat: 32'h0F0F1234});
    model_dat = 32'h0F0F1234;
    issue_req(1'b0, 4'h4, 4'hF, 32'h0);
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (dt !== 2) begin errors++; $display("FAIL post_reset_latency got %0d required 2", dt); end
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge clk);
    slv_stall = 0; slv_same = 1'b0; slv_resp = {0, 0}; slv_rdata = 32'hCAFEF00D;
    exp_q.push_back(exp_t'{resp: 2'b00, dat: model_dat});
    issue_req(1'b1, 4'h8, 4'h3, 32'h11112222);
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (done !== 1'b1 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got done=%b cyc=%b required 1/0", done, wb_cyc);
    end
    exp_q.push_back(exp_t'{resp: 2'b00, dat: 32'hCAFEF00D});
    model_dat = 32'hCAFEF00D;
    issue_req(1'b0, 4'hC, 4'hF, 32'h0);
    checks++;
    if (wb_stb !== 1'b1 || wb_adr !== 2'b11) begin
      errors++;
      $display("FAIL b2b_accept got stb=%b adr=%b required 1/11", wb_stb, wb_adr);
    end
    run_phase(20, sn, rs, gp, dt, af, df, wsf);
    checks++;
    if (dt !== 2) begin errors++; $display("FAIL b2b_latency got %0d required 2", dt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_retry();
    test_error();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
